button_event_ctrl: RTL and testbench

- Parametrised successor to the two-button manager: NUM_BTN active-low push buttons, each with its own synchroniser, debouncer and short/long press classifier.
- Classified events are queued in an event FIFO of depth FIFO_DEPTH, which the CPU drains over AHB-Lite through a read-to-pop register.
- Sits on the AHB-Lite bus as a slave beside the other cycle-computer peripherals. Adds a level-sensitive interrupt, live button levels and sticky overflow reporting.

---
 rtl/btn_evt_pkg.sv | 35 +++
 rtl/btn_channel.sv | 122 ++++++++++++
 rtl/button_event_ctrl.sv | 202 ++++++++++++++++++++
 tb/tb_button_event_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_evt_pkg.sv
// ---------------------------------------------------------------------------
// btn_evt_pkg
// Shared types and constants for the button event controller.
//   evt_type_e  : classified event type, encoded as it appears on the bus
//   cls_state_e : per-channel press classifier state
//   evt_entry_t : one event FIFO entry {type, channel}
//   ADDR_*      : register offsets, decoded from HADDR[3:2]
//   HTRANS_IDLE : AHB idle transfer encoding
// ---------------------------------------------------------------------------
package btn_evt_pkg;

  typedef enum logic [1:0] {
    EVT_NONE  = 2'b00,
    EVT_SHORT = 2'b01,
    EVT_LONG  = 2'b10
  } evt_type_e;

  typedef enum logic {
    CLS_IDLE = 1'b0,
    CLS_HELD = 1'b1
  } cls_state_e;

  typedef struct packed {
    evt_type_e   evt_type;
    logic [3:0]  chan;
  } evt_entry_t;

  localparam logic [1:0] ADDR_STATUS = 2'd0;
  localparam logic [1:0] ADDR_EVENT  = 2'd1;
  localparam logic [1:0] ADDR_LEVEL  = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

endpackage

// File: rtl/btn_channel.sv
// ---------------------------------------------------------------------------
// btn_channel
// One push-button channel: 2-flop synchroniser, debouncer and short/long
// press classifier.
// Ports:
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_n_button      : raw active-low button input (asynchronous)
//   o_level         : debounced stable level (1 = released)
//   o_pend_short    : one-cycle pulse, short press completed
//   o_pend_long     : one-cycle pulse, long press threshold reached
// ---------------------------------------------------------------------------
module btn_channel
  import btn_evt_pkg::*;
#(
  parameter int DEB_CYCLES  = 900,
  parameter int LONG_CYCLES = 16000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_n_button,
  output logic o_level,
  output logic o_pend_short,
  output logic o_pend_long
);

  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);

  logic              r_sync1;
  logic              r_sync2;
  logic              r_stable;
  logic [DEB_W-1:0]  r_deb_cnt;
  cls_state_e        r_state;
  cls_state_e        w_state_nxt;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [HOLD_W-1:0] w_hold_cnt_nxt;
  logic              w_flip;
  logic              w_press;
  logic              w_release;
  logic              w_short;
  logic              w_long;
  logic              r_pend_short;
  logic              r_pend_long;

  // Synchroniser resets to the released level so a quiet line never
  // produces a spurious press after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= i_n_button;
      r_sync2 <= r_sync1;
    end
  end

  // The flip happens on the cycle that would bring the count to DEB_CYCLES.
  assign w_flip    = (r_sync2 != r_stable) && (r_deb_cnt == DEB_W'(DEB_CYCLES - 1));
  assign w_press   = w_flip && r_stable;
  assign w_release = w_flip && !r_stable;

  // Debouncer: any cycle that agrees with the stable level restarts the count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_stable  <= 1'b1;
      r_deb_cnt <= '0;
    end else if (r_sync2 == r_stable) begin
      r_deb_cnt <= '0;
    end else if (w_flip) begin
      r_stable  <= r_sync2;
      r_deb_cnt <= '0;
    end else begin
      r_deb_cnt <= r_deb_cnt + DEB_W'(1);
    end
  end

  // Classifier: the hold counter saturates, so LONG fires exactly once and
  // a later release sees the counter at LONG_CYCLES and stays silent.
  always_comb begin
    w_state_nxt    = r_state;
    w_hold_cnt_nxt = r_hold_cnt;
    w_short        = 1'b0;
    w_long         = 1'b0;
    case (r_state)
      CLS_IDLE: begin
        if (w_press) begin
          w_state_nxt    = CLS_HELD;
          w_hold_cnt_nxt = '0;
        end
      end
      CLS_HELD: begin
        if (w_release) begin
          w_state_nxt = CLS_IDLE;
          w_short     = (r_hold_cnt < HOLD_W'(LONG_CYCLES));
        end else if (r_hold_cnt < HOLD_W'(LONG_CYCLES)) begin
          w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
          w_long         = (r_hold_cnt == HOLD_W'(LONG_CYCLES - 1));
        end
      end
      default: w_state_nxt = CLS_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= CLS_IDLE;
      r_hold_cnt   <= '0;
      r_pend_short <= 1'b0;
      r_pend_long  <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_hold_cnt   <= w_hold_cnt_nxt;
      r_pend_short <= w_short;
      r_pend_long  <= w_long;
    end
  end

  assign o_level      = r_stable;
  assign o_pend_short = r_pend_short;
  assign o_pend_long  = r_pend_long;

endmodule

// File: rtl/button_event_ctrl.sv
// ---------------------------------------------------------------------------
// button_event_ctrl
// AHB-Lite slave collecting short/long press events from NUM_BTN buttons
// into an event FIFO drained by the CPU through a read-to-pop register.
// Ports:
//   HCLK, HRESETn          : clock, asynchronous active-low reset
//   HADDR/HWDATA/HWRITE/
//   HREADY/HSEL/HSIZE/HTRANS : AHB-Lite slave inputs (HADDR[3:2] decoded)
//   nButton                : raw active-low buttons
//   HRDATA                 : read data, valid in the data phase
//   HREADYOUT              : always 1, zero wait states
//   IRQ                    : IRQ_EN and FIFO not empty
// Registers: 0x0 STATUS, 0x4 EVENT (read pops), 0x8 LEVEL, 0xC CTRL.
// ---------------------------------------------------------------------------
module button_event_ctrl
  import btn_evt_pkg::*;
#(
  parameter int NUM_BTN     = 4,
  parameter int DEB_CYCLES  = 900,
  parameter int LONG_CYCLES = 16000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic               HCLK,
  input  logic               HRESETn,
  input  logic [31:0]        HADDR,
  input  logic [31:0]        HWDATA,
  input  logic               HWRITE,
  input  logic               HREADY,
  input  logic               HSEL,
  input  logic [2:0]         HSIZE,
  input  logic [1:0]         HTRANS,
  input  logic [NUM_BTN-1:0] nButton,
  output logic [31:0]        HRDATA,
  output logic               HREADYOUT,
  output logic               IRQ
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = 6;

  logic [NUM_BTN-1:0] w_level;
  logic [NUM_BTN-1:0] w_pend_short;
  logic [NUM_BTN-1:0] w_pend_long;
  evt_type_e          r_pend [NUM_BTN];
  logic               w_grant_valid;
  logic [3:0]         w_grant_idx;
  evt_type_e          w_grant_type;
  evt_entry_t         r_fifo [FIFO_DEPTH];
  evt_entry_t         w_head;
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;
  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;
  logic               w_drop;
  logic               r_ovf;
  logic               r_irq_en;
  logic               r_dp_valid;
  logic               r_dp_write;
  logic [1:0]         r_dp_addr;
  logic               w_rd;
  logic               w_wr;
  logic               w_ctrl_wr;
  logic               w_unused;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_chan
    btn_channel #(
      .DEB_CYCLES  (DEB_CYCLES),
      .LONG_CYCLES (LONG_CYCLES)
    ) u_chan (
      .i_clk        (HCLK),
      .i_rst_n      (HRESETn),
      .i_n_button   (nButton[gi]),
      .o_level      (w_level[gi]),
      .o_pend_short (w_pend_short[gi]),
      .o_pend_long  (w_pend_long[gi])
    );
  end

  // Fixed priority: scanning downward leaves the lowest pending index granted.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_idx   = '0;
    w_grant_type  = EVT_NONE;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (r_pend[i] != EVT_NONE) begin
        w_grant_valid = 1'b1;
        w_grant_idx   = 4'(i);
        w_grant_type  = r_pend[i];
      end
    end
  end

  // A fresh pulse takes precedence over clearing a granted flag.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      for (int i = 0; i < NUM_BTN; i++) r_pend[i] <= EVT_NONE;
    end else begin
      for (int i = 0; i < NUM_BTN; i++) begin
        if (w_pend_long[i])
          r_pend[i] <= EVT_LONG;
        else if (w_pend_short[i])
          r_pend[i] <= EVT_SHORT;
        else if (w_grant_valid && (w_grant_idx == 4'(i)))
          r_pend[i] <= EVT_NONE;
      end
    end
  end

  // Address phase capture; the transfer acts in the following cycle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_dp_valid <= 1'b0;
      r_dp_write <= 1'b0;
      r_dp_addr  <= '0;
    end else begin
      r_dp_valid <= HSEL && HREADY && (HTRANS != HTRANS_IDLE);
      r_dp_write <= HWRITE;
      r_dp_addr  <= HADDR[3:2];
    end
  end

  assign w_rd      = r_dp_valid && !r_dp_write;
  assign w_wr      = r_dp_valid && r_dp_write;
  assign w_ctrl_wr = w_wr && (r_dp_addr == ADDR_CTRL);
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop     = w_rd && (r_dp_addr == ADDR_EVENT) && !w_empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign w_push    = w_grant_valid && (!w_full || w_pop);
  assign w_drop    = w_grant_valid && !w_push;
  assign w_head    = r_fifo[r_rd_ptr];

  // Entry storage needs no reset; only slots below r_count are ever read.
  always_ff @(posedge HCLK) begin
    if (w_push) r_fifo[r_wr_ptr] <= '{evt_type: w_grant_type, chan: w_grant_idx};
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Overflow is sticky; a drop in the same cycle as the clear keeps it set.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_ovf    <= 1'b0;
      r_irq_en <= 1'b0;
    end else begin
      if (w_drop)
        r_ovf <= 1'b1;
      else if (w_ctrl_wr && HWDATA[1])
        r_ovf <= 1'b0;
      if (w_ctrl_wr) r_irq_en <= HWDATA[0];
    end
  end

  // Read mux; EVENT returns the head combinationally while the pop lands at
  // the end of this data cycle.
  always_comb begin
    HRDATA = '0;
    if (w_rd) begin
      case (r_dp_addr)
        ADDR_STATUS: begin
          HRDATA[31]  = r_ovf;
          HRDATA[16]  = w_full;
          HRDATA[15]  = w_empty;
          HRDATA[5:0] = r_count;
        end
        ADDR_EVENT: begin
          if (!w_empty) begin
            HRDATA[31]  = 1'b1;
            HRDATA[9:8] = w_head.evt_type;
            HRDATA[3:0] = w_head.chan;
          end
        end
        ADDR_LEVEL: HRDATA[NUM_BTN-1:0] = ~w_level;
        ADDR_CTRL:  HRDATA[0] = r_irq_en;
        default:    HRDATA = '0;
      endcase
    end
  end

  assign HREADYOUT = 1'b1;
  assign IRQ       = r_irq_en && !w_empty;

  assign w_unused = ^{HSIZE, HADDR[31:4], HADDR[1:0], HWDATA[31:2]};

endmodule

// File: tb/tb_button_event_ctrl.sv
// ---------------------------------------------------------------------------
// tb_button_event_ctrl
// Directed bench for button_event_ctrl with default parameters
// (4 buttons, 900-cycle debounce, 16000-cycle long press, 8-entry FIFO).
// ---------------------------------------------------------------------------
module tb_button_event_ctrl;

  localparam logic [31:0] A_STATUS = 32'h0;
  localparam logic [31:0] A_EVENT  = 32'h4;
  localparam logic [31:0] A_LEVEL  = 32'h8;
  localparam logic [31:0] A_CTRL   = 32'hC;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic        HREADY;
  logic        HSEL;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic [3:0]  nButton;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        IRQ;

  int errors = 0;
  int checks = 0;

  always #5 HCLK = ~HCLK;

  button_event_ctrl #(
    .NUM_BTN     (4),
    .DEB_CYCLES  (900),
    .LONG_CYCLES (16000),
    .FIFO_DEPTH  (8)
  ) dut (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HADDR     (HADDR),
    .HWDATA    (HWDATA),
    .HWRITE    (HWRITE),
    .HREADY    (HREADY),
    .HSEL      (HSEL),
    .HSIZE     (HSIZE),
    .HTRANS    (HTRANS),
    .nButton   (nButton),
    .HRDATA    (HRDATA),
    .HREADYOUT (HREADYOUT),
    .IRQ       (IRQ)
  );

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge HCLK);
  endtask

  // Starts at a falling edge; returns at the data-phase falling edge.
  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b0;
    HADDR  = addr;
    @(negedge HCLK);
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HADDR  = '0;
    data   = HRDATA;
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b1;
    HADDR  = addr;
    @(negedge HCLK);
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HWRITE = 1'b0;
    HADDR  = '0;
    HWDATA = data;
    @(negedge HCLK);
  endtask

  // Button 3 is held through reset and must be accepted exactly
  // DEB_CYCLES+2 = 902 rising edges after reset release.
  task automatic test_reset();
    logic [31:0] rd;
    HRESETn = 1'b0;
    HADDR   = '0;
    HWDATA  = '0;
    HWRITE  = 1'b0;
    HREADY  = 1'b1;
    HSEL    = 1'b0;
    HSIZE   = 3'b010;
    HTRANS  = 2'b00;
    nButton = 4'b0111;
    wait_cycles(3);
    checks++;
    if (IRQ !== 1'b0) begin errors++; $display("[TB] FAIL reset_irq: got %b expected 0", IRQ); end
    checks++;
    if (HRDATA !== 32'h0) begin errors++; $display("[TB] FAIL reset_hrdata: got %h expected 00000000", HRDATA); end
    checks++;
    if (HREADYOUT !== 1'b1) begin errors++; $display("[TB] FAIL reset_hreadyout: got %b expected 1", HREADYOUT); end
    HRESETn = 1'b1;
    bus_read(A_STATUS, rd);
    checks++;
    if (rd !== 32'h0000_8000) begin errors++; $display("[TB] FAIL reset_status: got %h expected 00008000", rd); end
    bus_read(A_CTRL, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("[TB] FAIL reset_ctrl: got %h expected 00000000", rd); end
    bus_read(A_LEVEL, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("[TB] FAIL reset_level: got %h expected 00000000", rd); end
    wait_cycles(897);
    bus_read(A_LEVEL, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("[TB] FAIL held_through_reset_edge901: got %h expected 00000000", rd); end
    bus_read(A_LEVEL, rd);
    checks++;
    if (rd !== 32'h8) begin errors++; $display("[TB] FAIL held_through_reset_edge902: got %h expected 00000008", rd); end
    wait_cycles(500);
    nButton[3] = 1'b1;
    wait_cycles(1100);
    bus_read(A_EVENT, rd);
    checks++;
    if (rd !== 32'h8000_0103) begin errors++; $display("[TB] FAIL reset_press_event: got %h expected 80000103", rd); end
    bus_read(A_STATUS, rd);
    checks++;
    if (rd !== 32'h0000_8000) begin errors++; $display("[TB] FAIL reset_press_drained: got %h expected 00008000", rd); end
  endtask

  task automatic test_short_bounce();
    logic [31:0] rd;
    for (int k = 0; k < 50; k++) begin
      nButton[1] = k[1];
      @(negedge HCLK);
    end
    nButton[1] = 1'b0;
    wait_cycles(500);
    bus_read(A_LEVEL, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("[TB] FAIL short_level_before_accept: got %h expected 00000000", rd); end
    wait_cycles(1000);
    bus_read(A_LEVEL, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("[TB] FAIL short_level_held: got %h expected 00000002", rd); end
    wait_cycles(450);
    for (int k = 0; k < 50; k++) begin
      nButton[1] = ~k[1];
      @(negedge HCLK);
    end
    nButton[1] = 1'b1;
    wait_cycles(500);
    bus_read(A_LEVEL, rd);
    checks++;
    if (rd !== 32'h2) begin errors++; $display("[TB] FAIL short_level_release_debounce: got %h expected 00000002", rd); end
    wait_cycles(600);
    bus_read(A_LEVEL, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("[TB] FAIL short_level_released: got %h expected 00000000", rd); end
    bus_read(A_STATUS, rd);
    checks++;
    if (rd !== 32'h0000_0001) begin errors++; $display("[TB] FAIL short_status_count: got %h expected 00000001", rd); end
    bus_read(A_EVENT, rd);
    checks++;
    if (rd !== 32'h8000_0101) begin errors++; $display("[TB] FAIL short_event: got %h expected 80000101", rd); end
    bus_read(A_STATUS, rd);
    checks++;
    if (rd !== 32'h0000_8000) begin errors++; $display("[TB] FAIL short_status_empty: got %h expected 00008000", rd); end
    bus_read(A_EVENT, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("[TB] FAIL short_event_empty: got %h expected 00000000", rd); end
  endtask

  // Press accepted at edge 902, LONG pushed around edge 16904.
  task automatic test_long();
    logic [31:0] rd;
    nButton[0] = 1'b0;
    wait_cycles(16850);
    bus_read(A_STATUS, rd);
    checks++;
    if (rd !== 32'h0000_8000) begin errors++; $display("[TB] FAIL long_not_yet: got %h expected 00008000", rd); end
    wait_cycles(100);
    bus_read(A_STATUS, rd);
    checks++;
    if (rd !== 32'h0000_0001) begin errors++; $display("[TB] FAIL long_fired: got %h expected 00000001", rd); end
    wait_cycles(3048);
    nButton[0] = 1'b1;
    wait_cycles(1100);
    bus_read(A_STATUS, rd);
    checks++;
    if (rd !== 32'h0000_0001) begin errors++; $display("[TB] FAIL long_no_release_event: got %h expected 00000001", rd); end
    bus_read(A_EVENT, rd);
    checks++;
    if (rd !== 32'h8000_0200) begin errors++; $display("[TB] FAIL long_event: got %h expected 80000200", rd); end
    bus_read(A_EVENT, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("[TB] FAIL long_second_read: got %h expected 00000000", rd); end
  endtask

  task automatic test_simultaneous();
    logic [31:0] rd;
    nButton = 4'b0110;
    wait_cycles(1500);
    nButton = 4'b1111;
    wait_cycles(1100);
    bus_read(A_STATUS, rd);
    checks++;
    if (rd !== 32'h0000_0002) begin errors++; $display("[TB] FAIL simul_count: got %h expected 00000002", rd); end
    bus_read(A_EVENT, rd);
    checks++;
    if (rd !== 32'h8000_0100) begin errors++; $display("[TB] FAIL simul_first_ch0: got %h expected 80000100", rd); end
    bus_read(A_EVENT, rd);
    checks++;
    if (rd !== 32'h8000_0103) begin errors++; $display("[TB] FAIL simul_second_ch3: got %h expected 80000103", rd); end
    bus_read(A_STATUS, rd);
    checks++;
    if (rd !== 32'h0000_8000) begin errors++; $display("[TB] FAIL simul_empty: got %h expected 00008000", rd); end
  endtask

  // Two rounds of all four channels, then ch0 once more into a full FIFO.
  task automatic test_overflow();
    logic [31:0] rd;
    logic [3:0]  mask;
    logic [31:0] exp;
    for (int r = 0; r < 3; r++) begin
      mask    = (r < 2) ? 4'hF : 4'h1;
      nButton = ~mask;
      wait_cycles(1500);
      nButton = 4'hF;
      wait_cycles(1100);
    end
    bus_read(A_STATUS, rd);
    checks++;
    if (rd !== 32'h8001_0008) begin errors++; $display("[TB] FAIL ovf_status: got %h expected 80010008", rd); end
    bus_write(A_STATUS, 32'hFFFF_FFFF);
    bus_read(A_STATUS, rd);
    checks++;
    if (rd !== 32'h8001_0008) begin errors++; $display("[TB] FAIL ovf_ro_write_ignored: got %h expected 80010008", rd); end
    bus_write(A_CTRL, 32'h2);
    bus_read(A_STATUS, rd);
    checks++;
    if (rd !== 32'h0001_0008) begin errors++; $display("[TB] FAIL ovf_cleared: got %h expected 00010008", rd); end
    bus_read(A_CTRL, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("[TB] FAIL ovf_ctrl_readback: got %h expected 00000000", rd); end
    for (int k = 0; k < 8; k++) begin
      exp = 32'h8000_0100 | 32'(k % 4);
      bus_read(A_EVENT, rd);
      checks++;
      if (rd !== exp) begin errors++; $display("[TB] FAIL ovf_drain_%0d: got %h expected %h", k, rd, exp); end
    end
    bus_read(A_STATUS, rd);
    checks++;
    if (rd !== 32'h0000_8000) begin errors++; $display("[TB] FAIL ovf_drained: got %h expected 00008000", rd); end
  endtask

  task automatic test_irq();
    logic [31:0] rd;
    bus_write(A_CTRL, 32'h1);
    bus_read(A_CTRL, rd);
    checks++;
    if (rd !== 32'h1) begin errors++; $display("[TB] FAIL irq_ctrl_readback: got %h expected 00000001", rd); end
    checks++;
    if (IRQ !== 1'b0) begin errors++; $display("[TB] FAIL irq_low_when_empty: got %b expected 0", IRQ); end
    nButton[2] = 1'b0;
    wait_cycles(1500);
    nButton[2] = 1'b1;
    wait_cycles(1100);
    checks++;
    if (IRQ !== 1'b1) begin errors++; $display("[TB] FAIL irq_high_with_event: got %b expected 1", IRQ); end
    bus_read(A_EVENT, rd);
    checks++;
    if (rd !== 32'h8000_0102) begin errors++; $display("[TB] FAIL irq_event: got %h expected 80000102", rd); end
    checks++;
    if (IRQ !== 1'b1) begin errors++; $display("[TB] FAIL irq_during_data_phase: got %b expected 1", IRQ); end
    @(negedge HCLK);
    checks++;
    if (IRQ !== 1'b0) begin errors++; $display("[TB] FAIL irq_after_pop: got %b expected 0", IRQ); end
  endtask

  // IRQ_EN is still 1 from the previous test; ch2 leaves one event queued
  // while ch1 is held towards a hold count of about 10000.
  task automatic test_reset_mid_hold();
    logic [31:0] rd;
    nButton = 4'b1001;
    wait_cycles(1500);
    nButton[2] = 1'b1;
    wait_cycles(1100);
    checks++;
    if (IRQ !== 1'b1) begin errors++; $display("[TB] FAIL midrst_irq_before: got %b expected 1", IRQ); end
    wait_cycles(8302);
    HSEL   = 1'b1;
    HTRANS = 2'b10;
    HWRITE = 1'b0;
    HADDR  = A_STATUS;
    @(negedge HCLK);
    HSEL   = 1'b0;
    HTRANS = 2'b00;
    HADDR  = '0;
    checks++;
    if (HRDATA !== 32'h0000_0001) begin errors++; $display("[TB] FAIL midrst_status_before: got %h expected 00000001", HRDATA); end
    HRESETn = 1'b0;
    #1;
    checks++;
    if (IRQ !== 1'b0) begin errors++; $display("[TB] FAIL midrst_irq_in_reset: got %b expected 0", IRQ); end
    checks++;
    if (HRDATA !== 32'h0) begin errors++; $display("[TB] FAIL midrst_hrdata_in_reset: got %h expected 00000000", HRDATA); end
    checks++;
    if (HREADYOUT !== 1'b1) begin errors++; $display("[TB] FAIL midrst_hreadyout: got %b expected 1", HREADYOUT); end
    nButton = 4'hF;
    wait_cycles(3);
    HRESETn = 1'b1;
    wait_cycles(2000);
    bus_read(A_STATUS, rd);
    checks++;
    if (rd !== 32'h0000_8000) begin errors++; $display("[TB] FAIL midrst_status_after: got %h expected 00008000", rd); end
    bus_read(A_LEVEL, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("[TB] FAIL midrst_level_after: got %h expected 00000000", rd); end
    bus_read(A_CTRL, rd);
    checks++;
    if (rd !== 32'h0) begin errors++; $display("[TB] FAIL midrst_ctrl_after: got %h expected 00000000", rd); end
    checks++;
    if (IRQ !== 1'b0) begin errors++; $display("[TB] FAIL midrst_irq_after: got %b expected 0", IRQ); end
  endtask

  initial begin
    test_reset();
    test_short_bounce();
    test_long();
    test_simultaneous();
    test_overflow();
    test_irq();
    test_reset_mid_hold();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
